// File: rtl/riscv_pkg.sv
// riscv_pkg: shared fetch-stage defaults and the fetch FSM state encoding
package riscv_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        HOLD = 2'd3
    } state_t;

endpackage

// File: rtl/pc_fetch.sv
// pc_fetch: fetch-stage PC sequencer with memory handshake, stall, redirect and optional misalign trap
//   Build option MISALIGN_TRAP_EN: misaligned redirect targets trap to TRAP_VEC and pulse misalign_err;
//   otherwise redirect targets are word-aligned and misalign_err is held 0.
//   Ports: clk, rst (sync, active-high); pc out to the external PC+4 adder, pc_plus_4 back from it;
//   stall freezes PC advance; redirect_valid/redirect_target request a jump;
//   imem_req_valid/imem_req_ready/imem_req_addr form the fetch request channel;
//   imem_rsp_valid marks the returned instruction; instr_valid flags it live; misalign_err pulses on trap.
module pc_fetch
    import riscv_pkg::*;
#(
    parameter int               WIDTH    = XLEN,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(TRAP_VEC_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] pc_plus_4,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    output logic             instr_valid,
    output logic             misalign_err
);

    state_t           state;
    logic             pend_valid;
    logic [WIDTH-1:0] pend_tgt;
    logic [WIDTH-1:0] raw_tgt;
    logic [WIDTH-1:0] fix_tgt;
    logic [WIDTH-1:0] next_pc;
    logic             redir;
    logic             use_tgt;
    logic             bad;
    logic             rsp_hit;
    logic             advance;

    // A live redirect in the update cycle beats the pending one (last wins).
    assign redir   = redirect_valid && state != BOOT;
    assign raw_tgt = redirect_valid ? redirect_target : pend_tgt;
    assign use_tgt = redir || pend_valid;

`ifdef MISALIGN_TRAP_EN
    assign bad     = raw_tgt[1:0] != 2'b00;
    assign fix_tgt = raw_tgt;
`else
    assign bad     = 1'b0;
    assign fix_tgt = raw_tgt & ~WIDTH'(3);
`endif

    assign next_pc       = !use_tgt ? pc_plus_4 : bad ? TRAP_VEC : fix_tgt;
    assign rsp_hit       = state == RESP && imem_rsp_valid;
    assign advance       = !stall && (rsp_hit || state == HOLD);
    // Any redirect seen since this fetch was issued makes its response dead.
    assign instr_valid   = rsp_hit && !use_tgt;
    assign imem_req_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            pend_valid     <= 1'b0;
            pend_tgt       <= '0;
        end else begin
            if (advance) begin
                pc         <= next_pc;
                pend_valid <= 1'b0;
            end else if (redir) begin
                pend_valid <= 1'b1;
                pend_tgt   <= redirect_target;
            end
            case (state)
                BOOT: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: if (imem_req_ready) begin
                    state          <= RESP;
                    imem_req_valid <= 1'b0;
                end
                RESP: if (imem_rsp_valid) begin
                    state          <= stall ? HOLD : REQ;
                    imem_req_valid <= !stall;
                end
                default: if (!stall) begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
            endcase
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)
            misalign_err <= 1'b0;
        else
            misalign_err <= advance && use_tgt && bad;
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed vector table plus randomized run against a transaction-level fetch model
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        instr_valid;
    logic        misalign_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign pc_plus_4 = pc + 32'd4;

    pc_fetch dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .pc_plus_4(pc_plus_4),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .instr_valid(instr_valid),
        .misalign_err(misalign_err)
    );

`ifdef MISALIGN_TRAP_EN
    localparam logic [31:0] P  = 32'h0000_0100;
    localparam logic        ME = 1'b1;
`else
    localparam logic [31:0] P  = 32'h0000_0200;
    localparam logic        ME = 1'b0;
`endif

    typedef struct {
        logic        rst, stall, rdy, rsp, rv;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] ea;
        logic        eiv, eme;
    } vec_t;

    vec_t vt[$];

    task automatic row(input logic r, s, rd, rs, rv, input logic [31:0] t,
                       input logic ev, input logic [31:0] ea, input logic eiv, eme);
        vec_t v;
        v = '{r, s, rd, rs, rv, t, ev, ea, eiv, eme};
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fix(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00) ? 32'h0000_0100 : t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    function automatic logic trap(input logic [31:0] t);
`ifdef MISALIGN_TRAP_EN
        return t[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Fetch model: current fetch address, whether the request was accepted,
    // whether its response came back under stall, and redirects seen since the last PC update.
    logic [31:0] m_addr, m_tgt, tgt;
    logic        m_out, m_dlv, m_redir, m_kill, m_me, upd;
    logic        s, rd, rs, rv;

    initial begin
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;

        row(1,0,0,0,0,32'h0,          0,32'h0,0,0);
        row(0,0,0,1,1,32'h40,         0,32'h0,0,0);
        row(0,0,1,0,0,32'h0,          1,32'h0,0,0);
        row(0,0,0,1,0,32'h0,          0,32'h0,1,0);
        row(0,0,1,0,0,32'h0,          1,32'h4,0,0);
        row(0,0,0,1,0,32'h0,          0,32'h4,1,0);
        row(0,0,1,0,0,32'h0,          1,32'h8,0,0);
        row(0,1,0,1,0,32'h0,          0,32'h8,1,0);
        row(0,1,0,1,0,32'h0,          0,32'h8,0,0);
        row(0,1,0,0,0,32'h0,          0,32'h8,0,0);
        row(0,0,0,0,0,32'h0,          0,32'h8,0,0);
        row(0,0,1,0,0,32'h0,          1,32'hC,0,0);
        row(0,0,0,1,0,32'h0,          0,32'hC,1,0);
        for (int i = 0; i < 5; i++) row(0,0,0,0,0,32'h0, 1,32'h10,0,0);
        row(0,0,1,0,0,32'h0,          1,32'h10,0,0);
        row(0,0,0,0,1,32'h200,        0,32'h10,0,0);
        row(0,0,0,0,0,32'h0,          0,32'h10,0,0);
        row(0,0,0,1,0,32'h0,          0,32'h10,0,0);
        row(0,0,1,0,0,32'h0,          1,32'h200,0,0);
        row(0,0,0,1,1,32'h202,        0,32'h200,0,0);
        row(0,0,1,0,0,32'h0,          1,P,0,ME);
        row(0,0,0,1,0,32'h0,          0,P,1,0);
        row(0,0,0,0,1,32'hFFFF_FFFC,  1,P+32'h4,0,0);
        row(0,0,1,0,0,32'h0,          1,P+32'h4,0,0);
        row(0,0,0,1,0,32'h0,          0,P+32'h4,0,0);
        row(0,0,1,0,0,32'h0,          1,32'hFFFF_FFFC,0,0);
        row(0,0,0,1,0,32'h0,          0,32'hFFFF_FFFC,1,0);
        row(0,0,1,0,0,32'h0,          1,32'h0,0,0);
        row(0,0,0,1,0,32'h0,          0,32'h0,1,0);
        row(0,0,1,0,0,32'h0,          1,32'h4,0,0);
        row(1,0,0,0,0,32'h0,          0,32'h4,0,0);
        row(0,0,0,1,0,32'h0,          0,32'h0,0,0);
        row(0,0,0,0,0,32'h0,          1,32'h0,0,0);

        repeat (2) @(posedge clk);
        #1;
        foreach (vt[i]) begin
            rst             = vt[i].rst;
            stall           = vt[i].stall;
            imem_req_ready  = vt[i].rdy;
            imem_rsp_valid  = vt[i].rsp;
            redirect_valid  = vt[i].rv;
            redirect_target = vt[i].tgt;
            #3;
            chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].ea);
            chk($sformatf("vec%0d_pc", i), pc, vt[i].ea);
            chk($sformatf("vec%0d_instr_valid", i), 32'(instr_valid), 32'(vt[i].eiv));
            chk($sformatf("vec%0d_misalign", i), 32'(misalign_err), 32'(vt[i].eme));
            @(posedge clk);
            #1;
        end

        m_addr = 32'h0;
        m_tgt = 32'h0;
        m_out = 1'b0;
        m_dlv = 1'b0;
        m_redir = 1'b0;
        m_kill = 1'b0;
        m_me = 1'b0;
        rst = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            s  = ($urandom % 4) == 0;
            rd = ($urandom % 2) == 0;
            rv = ($urandom % 10) == 0;
            rs = m_out ? (($urandom % 2) == 0) : (($urandom % 8) == 0);
            tgt = 32'($urandom_range(0, 1023)) << 2;
            if (($urandom % 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            if (($urandom % 20) == 0) tgt = 32'hFFFF_FFFC;
            stall = s;
            imem_req_ready = rd;
            imem_rsp_valid = rs;
            redirect_valid = rv;
            redirect_target = tgt;
            #3;
            chk("rnd_req_valid", 32'(imem_req_valid), 32'(!m_out && !m_dlv));
            chk("rnd_req_addr", imem_req_addr, m_addr);
            chk("rnd_pc", pc, m_addr);
            chk("rnd_instr_valid", 32'(instr_valid), 32'(m_out && rs && !(m_kill || rv)));
            chk("rnd_misalign", 32'(misalign_err), 32'(m_me));
            upd = 1'b0;
            if (rv) begin
                m_redir = 1'b1;
                m_tgt = tgt;
                m_kill = 1'b1;
            end
            if (!m_out && !m_dlv) begin
                if (rd) m_out = 1'b1;
            end else if (m_out) begin
                if (rs) begin
                    m_out = 1'b0;
                    if (s) m_dlv = 1'b1;
                    else upd = 1'b1;
                end
            end else if (!s) begin
                m_dlv = 1'b0;
                upd = 1'b1;
            end
            m_me = upd && m_redir && trap(m_tgt);
            if (upd) begin
                m_addr = m_redir ? fix(m_tgt) : m_addr + 32'd4;
                m_redir = 1'b0;
                m_kill = 1'b0;
            end
            @(posedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the address and PC width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded by reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, SHALL set the misalignment trap target.
REQ-004 The block SHALL use one clock, clk, and a synchronous active-high reset, rst.
REQ-005 Ports SHALL be:
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- pc, out, WIDTH: current PC, fed to the external Adder.
- pc_plus_4, in, WIDTH: Adder result.
- stall, in, 1: freeze PC advance.
- redirect_valid, in, 1: branch/jump redirect.
- redirect_target, in, WIDTH: redirect address.
- imem_req_valid, out, 1: fetch request.
- imem_req_ready, in, 1: memory accepts the request.
- imem_req_addr, out, WIDTH: fetch address.
- imem_rsp_valid, in, 1: instruction returned.
- instr_valid, out, 1: returned instruction is architecturally live.
- misalign_err, out, 1: one-cycle misaligned-redirect pulse.

Function
REQ-006 States SHALL be BOOT, REQ, RESP and HOLD.
REQ-007 BOOT SHALL last exactly one cycle, then go to REQ.
REQ-008 In REQ, imem_req_valid=1 and imem_req_addr=pc.
- Both SHALL stay stable until imem_req_ready=1.
- On acceptance the state SHALL go to RESP.
REQ-009 In RESP, on imem_rsp_valid=1:
- instr_valid SHALL pulse for that cycle, unless the fetch is killed (REQ-012).
- stall=0: pc SHALL take next_pc, and the state SHALL go to REQ.
- stall=1: the state SHALL go to HOLD, with pc unchanged.
REQ-010 In HOLD, when stall=0, pc SHALL take next_pc and the state SHALL go to REQ.
REQ-011 next_pc SHALL be the pending redirect target if one exists, else pc_plus_4.
- pc_plus_4 wraps modulo 2^WIDTH (32'hFFFF_FFFC -> 0).
REQ-012 redirect_valid=1 in REQ, RESP or HOLD SHALL latch redirect_target into a pending register.
- A later redirect overwrites it (last wins).
- The in-flight fetch response SHALL be killed (instr_valid=0).
REQ-013 A redirect that coincides with imem_rsp_valid SHALL:
- kill that response;
- load pc directly from redirect_target in that cycle.
REQ-014 A redirect in REQ SHALL NOT alter the outstanding imem_req_addr. It takes effect at the next PC update.
REQ-015 The pending redirect flag SHALL clear when the redirect is consumed into pc.
REQ-016 redirect_valid in BOOT SHALL be ignored.
REQ-017 Latency SHALL be as follows:
- first imem_req_valid: second cycle after rst deasserts;
- response to next request: one cycle with stall=0.

Reset
REQ-018 rst=1 SHALL force, on the next clock edge regardless of state:
- state=BOOT;
- pc=RESET_PC;
- imem_req_valid=0, instr_valid=0, misalign_err=0;
- pending redirect cleared.
REQ-019 Reset mid-request SHALL abandon the outstanding fetch.
- Any imem_rsp_valid in BOOT SHALL be ignored.

Configuration
REQ-020 Macro MISALIGN_TRAP_EN defined:
- a redirect target with bits[1:0]!=0 SHALL load pc=TRAP_VEC instead;
- misalign_err SHALL pulse high for the cycle the PC is loaded.
REQ-021 Macro MISALIGN_TRAP_EN undefined:
- redirect target bits[1:0] SHALL be forced to 2'b00;
- misalign_err SHALL be tied 0.
- The port exists in both builds.

Structure
REQ-022 Shared package riscv_pkg SHALL hold:
- the WIDTH default;
- RESET_PC and TRAP_VEC defaults;
- the BOOT/REQ/RESP/HOLD state encoding.
REQ-023 No sub-module SHALL be instantiated internally. The PC+4 Adder is instantiated beside pc_fetch at the parent level, wired pc -> Adder -> pc_plus_4.

Verification
REQ-024 Reset then free run with ready=1 and rsp one cycle after accept:
- imem_req_addr = 0x0, 0x4, 0x8, ...;
- instr_valid once per fetch.
REQ-025 Back-pressure: imem_req_ready=0 for 5 cycles at pc=0x10 -> addr holds 0x10, valid stays 1, pc unchanged.
REQ-026 Redirect during RESP with target 0x200, rsp two cycles later:
- that rsp has instr_valid=0;
- next request addr=0x200.
REQ-027 stall=1 for 3 cycles during RESP at pc=0x8:
- the state goes to HOLD and pc stays 0x8;
- after release, the next request addr=0xC.
REQ-028 MISALIGN_TRAP_EN defined, redirect to 0x202 -> pc=0x100 and misalign_err=1 for one cycle. Macro undefined -> pc=0x200.
REQ-029 Wrap and reset:
- pc=32'hFFFF_FFFC advances to 0x0;
- rst asserted in RESP -> BOOT next cycle, pc=RESET_PC, a late rsp is ignored.
